// File: rtl/arb_req_agent.sv
// Packet-buffering requester for a round-robin arbiter: queues words in a FIFO,
// raises o_req once a whole packet (or a full FIFO) is waiting, then drains one packet per grant.
module arb_req_agent #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_vld,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_last,
  output logic              o_wr_rdy,
  output logic              o_req,
  input  logic              i_grant,
  output logic              o_dout_vld,
  output logic [DATA_W-1:0] o_dout_data,
  output logic              o_dout_last,
  input  logic              i_dout_rdy,
  output logic              o_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic              err_q, err_d;
  logic [DATA_W:0]   mem_q [DEPTH];

  logic              full, empty, wr_en, rd_en, head_last, pkt_inc, pkt_dec;
  logic [DATA_W:0]   head;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign head      = mem_q[rd_ptr_q];
  assign head_last = head[DATA_W];

  assign wr_en   = i_wr_vld && !full;
  assign rd_en   = (state_q == XFER) && !empty && i_dout_rdy;
  assign pkt_inc = wr_en && i_wr_last;
  assign pkt_dec = rd_en && head_last;

  assign o_wr_rdy    = !full;
  assign o_req       = (state_q == REQ);
  assign o_dout_vld  = (state_q == XFER) && !empty;
  assign o_dout_data = head[DATA_W-1:0];
  assign o_dout_last = head_last;
  assign o_err       = err_q;

  // Storage is data-only and never reset; validity is tracked by the pointers/count.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {i_wr_last, i_wr_data};
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    err_d     = err_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    case ({pkt_inc, pkt_dec})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    // A grant that arrives while not requesting is a protocol error from the arbiter side.
    if (i_grant && (state_q != REQ)) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if ((pkt_cnt_q != '0) || full) state_d = REQ;
      REQ:  if (i_grant) state_d = XFER;
      XFER: if (pkt_dec) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_arb_req_agent.sv
// Directed bench for arb_req_agent: a queue-based packet model checked every cycle,
// plus literal expectations for each scenario.
module tb_arb_req_agent;

  localparam int DW = 32;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst, wr_vld, wr_last, grant, dout_rdy;
  logic [DW-1:0] wr_data;
  logic          wr_rdy, req, dout_vld, dout_last, err;
  logic [DW-1:0] dout_data;

  int checks = 0;
  int errors = 0;

  arb_req_agent #(.DATA_W(DW), .DEPTH(DP)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_vld(wr_vld), .i_wr_data(wr_data), .i_wr_last(wr_last), .o_wr_rdy(wr_rdy),
    .o_req(req), .i_grant(grant),
    .o_dout_vld(dout_vld), .o_dout_data(dout_data), .o_dout_last(dout_last),
    .i_dout_rdy(dout_rdy), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: buffered words in order; mode 0=waiting, 1=requesting, 2=sending a packet.
  logic [DW:0] mq[$];
  int  mmode = 0;
  bit  merr  = 0;
  bit  mon   = 0;
  int  m_np;
  bit  m_wr, m_rd, m_plast;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mmode = 0;
      merr  = 0;
      mon   = 1;
    end else if (mon) begin
      m_np = 0;
      foreach (mq[i]) if (mq[i][DW]) m_np++;
      m_wr    = wr_vld && (mq.size() < DP);
      m_rd    = (mmode == 2) && (mq.size() > 0) && dout_rdy;
      m_plast = m_rd && mq[0][DW];
      if (grant && mmode != 1) merr = 1;
      case (mmode)
        0: if (m_np > 0 || mq.size() == DP) mmode = 1;
        1: if (grant) mmode = 2;
        default: if (m_plast) mmode = 0;
      endcase
      if (m_rd) void'(mq.pop_front());
      if (m_wr) mq.push_back({wr_last, wr_data});
    end
  end

  always @(negedge clk) begin
    if (mon) begin
      chk("m_wr_rdy", wr_rdy, mq.size() < DP);
      chk("m_req", req, mmode == 1);
      chk("m_dout_vld", dout_vld, (mmode == 2) && (mq.size() > 0));
      chk("m_err", err, merr);
      if ((mmode == 2) && (mq.size() > 0)) begin
        chk("m_dout_data", dout_data, mq[0][DW-1:0]);
        chk("m_dout_last", dout_last, mq[0][DW]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic l);
    wr_vld = 1'b1; wr_data = d; wr_last = l;
    step();
    wr_vld = 1'b0; wr_last = 1'b0;
  endtask

  task automatic pulse_grant();
    grant = 1'b1;
    step();
    grant = 1'b0;
  endtask

  int n, outcnt;
  bit granted, full_checked;

  initial begin
    rst = 1'b1; wr_vld = 1'b0; wr_data = '0; wr_last = 1'b0; grant = 1'b0; dout_rdy = 1'b1;
    step(); step();
    chk("rst_wr_rdy", wr_rdy, 1); chk("rst_req", req, 0);
    chk("rst_vld", dout_vld, 0);  chk("rst_err", err, 0);
    rst = 1'b0;

    // 3-word packet, single grant pulse
    wr(32'hA000_0001, 0); wr(32'hA000_0002, 0); wr(32'hA000_0003, 1);
    chk("a_req_pre", req, 0);
    step();
    chk("a_req", req, 1);
    pulse_grant();
    chk("a_req_drop", req, 0); chk("a_d1", dout_data, 32'hA000_0001);
    chk("a_v1", dout_vld, 1);  chk("a_l1", dout_last, 0);
    step(); chk("a_d2", dout_data, 32'hA000_0002); chk("a_l2", dout_last, 0);
    step(); chk("a_d3", dout_data, 32'hA000_0003); chk("a_l3", dout_last, 1);
    step(); chk("a_idle_vld", dout_vld, 0); chk("a_idle_req", req, 0);

    // downstream stall for 5 cycles
    wr(32'hB000_0001, 0); wr(32'hB000_0002, 1);
    step(); chk("b_req", req, 1);
    dout_rdy = 1'b0;
    pulse_grant();
    for (int i = 0; i < 5; i++) begin
      chk("b_hold_vld", dout_vld, 1); chk("b_hold_data", dout_data, 32'hB000_0001);
      step();
    end
    dout_rdy = 1'b1;
    chk("b_rel", dout_data, 32'hB000_0001);
    step(); chk("b_d2", dout_data, 32'hB000_0002); chk("b_l2", dout_last, 1);
    step(); chk("b_idle", dout_vld, 0);

    // two packets back-to-back, one grant each
    wr(32'hC000_0001, 0); wr(32'hC000_0002, 1); wr(32'hD000_0001, 0); wr(32'hD000_0002, 1);
    chk("c_req", req, 1);
    pulse_grant();
    chk("c_d1", dout_data, 32'hC000_0001);
    step(); chk("c_d2", dout_data, 32'hC000_0002); chk("c_l2", dout_last, 1);
    step(); chk("c_idle_req", req, 0); chk("c_idle_vld", dout_vld, 0);
    step(); chk("c_rereq", req, 1);
    pulse_grant();
    chk("d_d1", dout_data, 32'hD000_0001);
    step(); chk("d_d2", dout_data, 32'hD000_0002);
    step(); chk("d_idle", req, 0);

    // last-word write coinciding with last-word pop
    wr(32'hE000_0001, 1);
    step(); chk("e_req", req, 1);
    pulse_grant();
    chk("e_d1", dout_data, 32'hE000_0001);
    wr(32'hF000_0001, 1);
    chk("e_idle_vld", dout_vld, 0); chk("e_idle_req", req, 0);
    step(); chk("f_req", req, 1);
    pulse_grant();
    chk("f_d1", dout_data, 32'hF000_0001); chk("f_l1", dout_last, 1);
    step(); step(); chk("f_done_req", req, 0);

    // 12-word packet longer than the FIFO
    n = 0; outcnt = 0; granted = 0; full_checked = 0;
    for (int c = 0; c < 200 && outcnt < 12; c++) begin
      wr_vld  = (n < 12);
      wr_data = 32'h100 + n;
      wr_last = (n == 11);
      if (n == 8 && !full_checked) begin
        chk("g_full", wr_rdy, 0);
        full_checked = 1;
      end
      grant = req && (n >= 8) && !granted;
      if (grant) granted = 1;
      if (dout_vld && dout_rdy) begin
        chk("g_word", dout_data, 32'h100 + outcnt);
        chk("g_last", dout_last, outcnt == 11);
        outcnt++;
      end
      if (wr_vld && wr_rdy) n++;
      step();
      grant = 1'b0;
    end
    wr_vld = 1'b0; wr_last = 1'b0;
    chk("g_count", outcnt, 12);
    chk("g_full_seen", full_checked, 1);
    chk("g_rdy_back", wr_rdy, 1);

    // grant held over several cycles: one transfer, extra cycles flagged as error
    step();
    wr(32'h7000_0001, 1);
    step(); chk("h_req", req, 1);
    grant = 1'b1;
    step(); chk("h_d1", dout_data, 32'h7000_0001);
    step(); step();
    grant = 1'b0;
    chk("h_vld", dout_vld, 0); chk("h_req_off", req, 0); chk("h_err", err, 1);

    // reset clears error; grant in the reset cycle is ignored
    rst = 1'b1; grant = 1'b1;
    step();
    rst = 1'b0; grant = 1'b0;
    chk("r_err0", err, 0);
    step(); chk("r_err_stay0", err, 0);

    // grant while idle and empty
    pulse_grant();
    chk("i_err", err, 1); chk("i_vld", dout_vld, 0);
    step(); step(); chk("i_err_sticky", err, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("i_rst_err", err, 0); chk("i_rst_req", req, 0); chk("i_rst_rdy", wr_rdy, 1);

    // reset mid-packet discards buffered words
    wr(32'h9000_0001, 0); wr(32'h9000_0002, 0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("m_rdy", wr_rdy, 1);
    step(); step(); chk("m_noreq", req, 0);
    wr(32'h9000_0003, 1);
    step(); chk("m_req", req, 1);
    pulse_grant();
    chk("m_first", dout_data, 32'h9000_0003); chk("m_last", dout_last, 1);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/arb_req_agent.md
ARB_REQ_AGENT -- requirements
Module: arb_req_agent

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of a data word.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; power of 2, at least 2.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_wr_vld  input  1  upstream word valid.
REQ-006 SHALL have port i_wr_data  input  DATA_W  upstream word.
REQ-007 SHALL have port i_wr_last  input  1  word is last of its packet.
REQ-008 SHALL have port o_wr_rdy  output  1  FIFO can accept a word.
REQ-009 SHALL have port o_req  output  1  request to the round-robin arbiter (one bit of its i_req vector).
REQ-010 SHALL have port i_grant  input  1  grant bit from arbiter; registered, at most one cycle wide.
REQ-011 SHALL have port o_dout_vld  output  1  granted-packet word valid.
REQ-012 SHALL have port o_dout_data  output  DATA_W  granted-packet word.
REQ-013 SHALL have port o_dout_last  output  1  last word of the granted packet.
REQ-014 SHALL have port i_dout_rdy  input  1  downstream accepts the word.
REQ-015 SHALL have port o_err  output  1  sticky: grant received outside REQ state.

Function
REQ-016 SHALL store {last, data} in a DEPTH-entry FIFO; write when i_wr_vld && o_wr_rdy; o_wr_rdy = !full (combinational from registered state).
REQ-017 SHALL keep pkt_cnt, width clog2(DEPTH+1): +1 on accepted write with i_wr_last, -1 on accepted output with o_dout_last, unchanged when both in the same cycle.
REQ-018 SHALL keep FIFO pointers and pkt_cnt wrap-free: pointers wrap modulo DEPTH; no write when full, no read when empty.
REQ-019 SHALL implement FSM IDLE, REQ, XFER.
REQ-020 IDLE -> REQ when pkt_cnt > 0 or FIFO full (cut-through for packets longer than DEPTH).
REQ-021 o_req SHALL be 1 exactly while state == REQ (decoded from state register, no combinational path from i_grant).
REQ-022 REQ -> XFER on the edge where i_grant == 1; o_req therefore deasserts the cycle after the grant pulse, so no second grant is issued for the same packet.
REQ-023 In XFER, o_dout_vld = !empty; o_dout_data/o_dout_last = FIFO head; a word is popped when o_dout_vld && i_dout_rdy.
REQ-024 XFER -> IDLE on the pop of a word with last=1; if FIFO empties mid-packet, SHALL stay in XFER with o_dout_vld=0 until data arrives.
REQ-025 o_dout_vld SHALL be 0 in IDLE and REQ.
REQ-026 Write into empty FIFO SHALL be visible at head on the following cycle (no bypass).
REQ-027 Writes SHALL continue to be accepted in every state, including XFER, subject only to full.
REQ-028 i_grant == 1 while state != REQ SHALL be ignored for the FSM and SHALL set o_err to 1 until reset.
REQ-029 Held i_grant over multiple cycles SHALL cause exactly one REQ -> XFER transition.

Reset
REQ-030 On i_rst == 1 at a clock edge: state=IDLE, pointers=0, pkt_cnt=0, o_err=0; hence o_req=0, o_dout_vld=0, o_wr_rdy=1; FIFO contents need not be cleared.
REQ-031 Reset mid-packet (any state) SHALL discard all buffered words; any grant in the reset cycle is ignored and does not set o_err.

Verification
REQ-032 3-word packet A1,A2,A3(last), i_dout_rdy=1 -> o_req=1 the cycle after pkt_cnt becomes 1; grant pulse at cycle t -> o_req=0 and dout A1,A2,A3 at t+1..t+3, o_dout_last only with A3, state IDLE at t+4.
REQ-033 DEPTH=8, 12-word packet without early grant -> o_wr_rdy=0 after 8 words, o_req=1 due to full; after grant words drain, o_wr_rdy returns, all 12 words out in order, last on word 12.
REQ-034 Two 2-word packets back-to-back, one grant -> only first packet output, FSM returns IDLE, o_req reasserts next cycle for second packet (pkt_cnt=1).
REQ-035 i_dout_rdy=0 for 5 cycles in XFER -> o_dout_vld/data held stable, no pop, pkt_cnt unchanged.
REQ-036 Grant pulse while IDLE with empty FIFO -> no output, o_err=1 and stays 1; i_rst=1 -> o_err=0, o_req=0, o_wr_rdy=1.
REQ-037 Simultaneous last-word write and last-word pop -> pkt_cnt unchanged, no word lost or duplicated.
